// File: rtl/phys_free_list.sv
// Physical-register free list: a circular FIFO of free tags that hands out up
// to two tags per cycle to rename and takes back up to two per cycle from retire.
module phys_free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32,
  parameter int TAG_W     = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_req_0,
  input  logic             alloc_req_1,
  output logic             alloc_gnt,
  output logic [TAG_W-1:0] alloc_tag_0,
  output logic [TAG_W-1:0] alloc_tag_1,
  input  logic             free_valid_0,
  input  logic             free_valid_1,
  input  logic [TAG_W-1:0] free_tag_0,
  input  logic [TAG_W-1:0] free_tag_1,
  output logic [5:0]       free_count,
  output logic             empty,
  output logic             overflow_err
);

  // DEPTH must be a power of two so pointer wrap is a plain increment.
  localparam int DEPTH = NUM_PREGS - NUM_AREGS;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = 6;

  logic [TAG_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [CNT_W-1:0] n_req;
  logic [CNT_W-1:0] n_alloc;
  logic [CNT_W-1:0] n_free;
  logic [CNT_W-1:0] space;
  logic             acc_0;
  logic             acc_1;
  logic             rej_any;
  logic [PTR_W-1:0] head_1;
  logic [PTR_W-1:0] wr_ptr_1;

  always_comb begin
    n_req     = CNT_W'(alloc_req_0) + CNT_W'(alloc_req_1);
    alloc_gnt = (n_req != '0) && (count >= n_req);
    n_alloc   = alloc_gnt ? n_req : '0;
    // Room left for returned tags once this cycle's allocation is taken out.
    space     = CNT_W'(DEPTH) - (count - n_alloc);
    acc_0     = free_valid_0 && (free_tag_0 != '0) && (space >= CNT_W'(1));
    acc_1     = free_valid_1 && (free_tag_1 != '0) &&
                (space >= (acc_0 ? CNT_W'(2) : CNT_W'(1)));
    n_free    = CNT_W'(acc_0) + CNT_W'(acc_1);
    rej_any   = (free_valid_0 && !acc_0) || (free_valid_1 && !acc_1);
    head_1    = head + PTR_W'(1);
    // Accepted frees are packed so a rejected lane 0 leaves no hole.
    wr_ptr_1  = acc_0 ? tail + PTR_W'(1) : tail;
  end

  assign alloc_tag_0 = mem[head];
  assign alloc_tag_1 = alloc_req_0 ? mem[head_1] : mem[head];
  assign free_count  = count;
  assign empty       = (count == '0);

  // At reset p0..p31 hold the architectural state, so the list starts as p32..p63.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= TAG_W'(NUM_AREGS + i);
      end
      head         <= '0;
      tail         <= '0;
      count        <= CNT_W'(DEPTH);
      overflow_err <= 1'b0;
    end else begin
      if (acc_0) mem[tail] <= free_tag_0;
      if (acc_1) mem[wr_ptr_1] <= free_tag_1;
      head  <= head + PTR_W'(n_alloc);
      tail  <= tail + PTR_W'(n_free);
      count <= count - n_alloc + n_free;
      if (rej_any) overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_phys_free_list.sv
// Self-checking bench for phys_free_list: directed scenarios followed by random
// traffic, all compared against a queue-based model of the free list.
module tb_phys_free_list;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       alloc_req_0 = 1'b0;
  logic       alloc_req_1 = 1'b0;
  logic       alloc_gnt;
  logic [6:0] alloc_tag_0;
  logic [6:0] alloc_tag_1;
  logic       free_valid_0 = 1'b0;
  logic       free_valid_1 = 1'b0;
  logic [6:0] free_tag_0 = '0;
  logic [6:0] free_tag_1 = '0;
  logic [5:0] free_count;
  logic       empty;
  logic       overflow_err;

  int tests = 0;
  int fails = 0;

  // Model: the free list is just an ordered queue of tags plus a sticky error bit.
  int q[$];
  bit m_err;

  phys_free_list dut (
    .clk          (clk),
    .reset        (reset),
    .alloc_req_0  (alloc_req_0),
    .alloc_req_1  (alloc_req_1),
    .alloc_gnt    (alloc_gnt),
    .alloc_tag_0  (alloc_tag_0),
    .alloc_tag_1  (alloc_tag_1),
    .free_valid_0 (free_valid_0),
    .free_valid_1 (free_valid_1),
    .free_tag_0   (free_tag_0),
    .free_tag_1   (free_tag_1),
    .free_count   (free_count),
    .empty        (empty),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 32; i < 64; i++) q.push_back(i);
    m_err = 1'b0;
  endtask

  // Drive one cycle: set inputs, check combinational and registered outputs
  // against the model, then advance the clock and update the model.
  task automatic apply_stimulus(input bit r0, input bit r1,
                                input bit fv0, input int t0,
                                input bit fv1, input int t1);
    int  nreq;
    bit  gnt;
    int  idx1;
    alloc_req_0  = r0;
    alloc_req_1  = r1;
    free_valid_0 = fv0;
    free_tag_0   = 7'(t0);
    free_valid_1 = fv1;
    free_tag_1   = 7'(t1);
    #1;
    nreq = int'(r0) + int'(r1);
    gnt  = (nreq != 0) && (q.size() >= nreq);
    idx1 = r0 ? 1 : 0;
    check_output("alloc_gnt", 32'(alloc_gnt), 32'(gnt));
    check_output("free_count", 32'(free_count), 32'(q.size()));
    check_output("empty", 32'(empty), 32'(q.size() == 0));
    check_output("overflow_err", 32'(overflow_err), 32'(m_err));
    if (q.size() >= 1) check_output("alloc_tag_0", 32'(alloc_tag_0), 32'(q[0]));
    if (q.size() > idx1) check_output("alloc_tag_1", 32'(alloc_tag_1), 32'(q[idx1]));
    @(posedge clk);
    #1;
    if (gnt) for (int i = 0; i < nreq; i++) void'(q.pop_front());
    if (fv0) begin
      if (t0 == 0 || q.size() >= 32) m_err = 1'b1;
      else q.push_back(t0);
    end
    if (fv1) begin
      if (t1 == 0 || q.size() >= 32) m_err = 1'b1;
      else q.push_back(t1);
    end
  endtask

  // Reset with random traffic on the inputs, which must all be discarded.
  task automatic do_reset();
    reset        = 1'b1;
    alloc_req_0  = 1'($urandom);
    alloc_req_1  = 1'($urandom);
    free_valid_0 = 1'($urandom);
    free_valid_1 = 1'($urandom);
    free_tag_0   = 7'($urandom_range(1, 63));
    free_tag_1   = 7'($urandom_range(1, 63));
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #1;
    do_reset();

    // Dual allocation straight out of reset.
    apply_stimulus(1, 1, 0, 0, 0, 0);
    check_output("plan_count_30", 32'(free_count), 32'd30);
    apply_stimulus(1, 0, 0, 0, 0, 0);

    // Lane 1 alone takes the head entry.
    do_reset();
    apply_stimulus(0, 1, 0, 0, 0, 0);
    check_output("plan_count_31", 32'(free_count), 32'd31);

    // Drain completely, then a single request is refused.
    do_reset();
    for (int i = 0; i < 16; i++) apply_stimulus(1, 1, 0, 0, 0, 0);
    check_output("plan_empty", 32'(empty), 32'd1);
    apply_stimulus(1, 0, 0, 0, 0, 0);
    check_output("plan_count_0", 32'(free_count), 32'd0);

    // One free tag: dual request refused, single request granted.
    do_reset();
    for (int i = 0; i < 15; i++) apply_stimulus(1, 1, 0, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 0, 0);
    apply_stimulus(1, 1, 0, 0, 0, 0);
    check_output("plan_count_1", 32'(free_count), 32'd1);
    apply_stimulus(1, 0, 0, 0, 0, 0);

    // Empty list: frees in cycle N are allocatable only in N+1.
    apply_stimulus(1, 0, 1, 7, 1, 9);
    check_output("plan_count_2", 32'(free_count), 32'd2);
    apply_stimulus(1, 1, 0, 0, 0, 0);

    // Free into a full list.
    do_reset();
    apply_stimulus(0, 0, 1, 40, 0, 0);
    check_output("plan_full_err", 32'(overflow_err), 32'd1);
    check_output("plan_full_count", 32'(free_count), 32'd32);
    apply_stimulus(0, 0, 0, 0, 0, 0);

    // Returning p0 is illegal.
    do_reset();
    apply_stimulus(1, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 1, 0, 0, 0);
    check_output("plan_zero_err", 32'(overflow_err), 32'd1);
    apply_stimulus(0, 0, 0, 0, 0, 0);

    // Wrap both pointers with paired alloc/free traffic.
    do_reset();
    for (int i = 0; i < 40; i++) apply_stimulus(1, 0, 1, $urandom_range(1, 63), 0, 0);
    apply_stimulus(1, 1, 0, 0, 0, 0);

    // Random traffic with occasional mid-operation resets.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset();
      end else begin
        apply_stimulus(1'($urandom), 1'($urandom),
                       ($urandom_range(0, 2) != 0),
                       ($urandom_range(0, 49) == 0) ? 0 : $urandom_range(1, 63),
                       ($urandom_range(0, 2) != 0),
                       ($urandom_range(0, 49) == 0) ? 0 : $urandom_range(1, 63));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
